direction_conditioner: RTL and testbench



---
 rtl/direction_conditioner_if.sv | 19 +
 rtl/direction_conditioner.sv | 180 ++++++++++++++++++
 tb/tb_direction_conditioner.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/direction_conditioner_if.sv
// Key/direction bundle between the raw button inputs and the direction conditioner.
// The driver of the raw keys takes master; the conditioner takes slave.
interface direction_conditioner_if;
  logic [3:0] key_n;
  logic [3:0] player_direction;
  logic [3:0] key_stable;

  modport master (
    output key_n,
    input  player_direction,
    input  key_stable
  );

  modport slave (
    input  key_n,
    output player_direction,
    output key_stable
  );
endinterface

// File: rtl/direction_conditioner.sv
// Synchronise, debounce and one-hot encode the four active-low direction buttons.
// Optional auto-repeat gaps are compiled in when DIR_REPEAT_EN is defined.
module direction_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 12500000,
  parameter int unsigned GAP_CYCLES      = 4
) (
  input logic                     clock,
  input logic                     reset_n,
  direction_conditioner_if.slave  bus
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

`ifdef DIR_REPEAT_EN
  localparam int unsigned RcW = $clog2(REPEAT_CYCLES + 1);
  localparam int unsigned GcW = $clog2(GAP_CYCLES + 1);
  localparam logic [RcW-1:0] RcMax = RcW'(REPEAT_CYCLES - 1);
  localparam logic [GcW-1:0] GcMax = GcW'(GAP_CYCLES - 1);
`endif

`ifdef DIR_REPEAT_EN
  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StHold} state_e;
`endif

  // Two-flop synchroniser; flops idle at 1 (released).
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] synced;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= bus.key_n;
      sync2_q <= sync1_q;
    end
  end

  assign synced = ~sync2_q;

  // Per-key debounce: stable level moves only after DEBOUNCE_CYCLES consecutive disagreements.
  logic [3:0]           stable_q, stable_d;
  logic [3:0][DbW-1:0]  db_cnt_q, db_cnt_d;

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (synced[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          stable_d[i] = synced[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      db_cnt_q <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign bus.key_stable = stable_q;

  // Ambiguous chords produce no direction at all.
  logic [3:0] cand;
  assign cand = $onehot(stable_q) ? stable_q : 4'b0000;

  state_e     state_q, state_d;
  logic [3:0] dir_q, dir_d;
  logic [3:0] out_q, out_d;
`ifdef DIR_REPEAT_EN
  logic [RcW-1:0] rcnt_q, rcnt_d;
  logic [GcW-1:0] gcnt_q, gcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    out_d   = out_q;
`ifdef DIR_REPEAT_EN
    rcnt_d  = rcnt_q;
    gcnt_d  = gcnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        out_d = '0;
        if (cand != '0) begin
          state_d = StHold;
          dir_d   = cand;
          out_d   = cand;
`ifdef DIR_REPEAT_EN
          rcnt_d  = '0;
`endif
        end
      end
      StHold: begin
        if (cand == '0) begin
          state_d = StIdle;
          out_d   = '0;
        end else if (cand != dir_q) begin
          // Direction switch is immediate; no gap inserted.
          dir_d   = cand;
          out_d   = cand;
`ifdef DIR_REPEAT_EN
          rcnt_d  = '0;
`endif
        end else begin
          out_d = dir_q;
`ifdef DIR_REPEAT_EN
          if (rcnt_q == RcMax) begin
            state_d = StGap;
            out_d   = '0;
            gcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
`endif
        end
      end
`ifdef DIR_REPEAT_EN
      StGap: begin
        // Key changes are ignored until the gap has fully elapsed.
        out_d = '0;
        if (gcnt_q == GcMax) begin
          if (cand == dir_q) begin
            state_d = StHold;
            out_d   = dir_q;
            rcnt_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        out_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      dir_q   <= '0;
      out_q   <= '0;
`ifdef DIR_REPEAT_EN
      rcnt_q  <= '0;
      gcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
`ifdef DIR_REPEAT_EN
      rcnt_q  <= rcnt_d;
      gcnt_q  <= gcnt_d;
`endif
    end
  end

  assign bus.player_direction = out_q;

endmodule

// File: tb/tb_direction_conditioner.sv
// Bench for direction_conditioner: directed scenarios plus random key activity,
// every cycle checked against a timestamp-based behavioural model.
module tb_direction_conditioner;

  localparam int DebounceCycles = 4;
  localparam int RepeatCycles   = 20;
  localparam int GapCycles      = 4;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  direction_conditioner_if bus ();

  direction_conditioner #(
    .DEBOUNCE_CYCLES (DebounceCycles),
    .REPEAT_CYCLES   (RepeatCycles),
    .GAP_CYCLES      (GapCycles)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state: raw press history per edge, debounced levels, output timeline.
  logic [3:0] raw_hist[$];
  logic [3:0] m_stable;
  logic [3:0] m_out;
  logic [3:0] m_dir;
  int         m_mode;  // 0 none, 1 holding, 2 in repeat gap
  int         cyc;
  int         hold_start;
  int         gap_exit;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    raw_hist.delete();
    for (int i = 0; i < DebounceCycles + 2; i++) raw_hist.push_back(4'b0000);
    m_stable   = '0;
    m_out      = '0;
    m_dir      = '0;
    m_mode     = 0;
    cyc        = 0;
    hold_start = 0;
    gap_exit   = 0;
  endtask

  task automatic model_edge();
    logic [3:0] cand;
    logic [3:0] nstable;
    logic       v;
    logic       same;
    cyc++;
    cand = ($countones(m_stable) == 1) ? m_stable : 4'b0000;
    case (m_mode)
      0: begin
        if (cand != 0) begin
          m_mode = 1; m_dir = cand; m_out = cand; hold_start = cyc;
        end
      end
      1: begin
        if (cand == 0) begin
          m_mode = 0; m_out = 0;
        end else if (cand != m_dir) begin
          m_dir = cand; m_out = cand; hold_start = cyc;
        end
`ifdef DIR_REPEAT_EN
        else if (cyc - hold_start == RepeatCycles) begin
          m_mode = 2; m_out = 0; gap_exit = cyc + GapCycles;
        end
`endif
      end
      default: begin
        if (cyc == gap_exit) begin
          if (cand == m_dir) begin
            m_mode = 1; m_out = m_dir; hold_start = cyc;
          end else begin
            m_mode = 0;
          end
        end
      end
    endcase
    // Synced value seen at this edge is the raw sample from two edges back;
    // a key flips once the last DebounceCycles synced samples all disagree.
    nstable = m_stable;
    for (int b = 0; b < 4; b++) begin
      v    = raw_hist[1][b];
      same = 1'b1;
      for (int j = 1; j <= DebounceCycles; j++) if (raw_hist[j][b] != v) same = 1'b0;
      if (same && (v != m_stable[b])) nstable[b] = v;
    end
    m_stable = nstable;
    raw_hist.push_back(~bus.key_n);
    void'(raw_hist.pop_front());
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_edge();
    @(negedge clock);
    check("model_dir", bus.player_direction, m_out);
    check("model_stable", bus.key_stable, m_stable);
  endtask

  task automatic wait_dir(input logic [3:0] exp, input string tag);
    int n;
    n = 0;
    while (bus.player_direction !== exp && n < 30) begin
      tick();
      n++;
    end
    check(tag, bus.player_direction, exp);
  endtask

  initial begin
    logic [3:0] pat;
    int         len;
    int         sel;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.key_n = 4'hF;
    model_reset();
    repeat (3) @(negedge clock);
    check("reset_dir", bus.player_direction, 4'b0000);
    check("reset_stable", bus.key_stable, 4'b0000);
    reset_n = 1'b1;
    repeat (3) tick();

    // 1: single press latency and release latency
    bus.key_n = 4'b1110;
    repeat (5) tick();
    check("t1_stable_early", bus.key_stable, 4'b0000);
    tick();
    check("t1_stable_edge6", bus.key_stable, 4'b0001);
    check("t1_dir_edge6", bus.player_direction, 4'b0000);
    tick();
    check("t1_dir_edge7", bus.player_direction, 4'b0001);
    repeat (3) tick();
    bus.key_n = 4'hF;
    repeat (6) tick();
    check("t1_rel_stable", bus.key_stable, 4'b0000);
    check("t1_rel_dir_held", bus.player_direction, 4'b0001);
    tick();
    check("t1_rel_dir", bus.player_direction, 4'b0000);
    repeat (3) tick();

    // 2: bounce never reaches the debounce threshold
    bus.key_n = 4'b1011;
    repeat (3) tick();
    bus.key_n = 4'hF;
    tick();
    bus.key_n = 4'b1011;
    repeat (3) tick();
    bus.key_n = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_stable", bus.key_stable, 4'b0000);
      check("t2_dir", bus.player_direction, 4'b0000);
    end

    // 3: chord gives nothing; releasing LEFT leaves UP
    bus.key_n = 4'b0110;
    repeat (10) tick();
    check("t3_chord_stable", bus.key_stable, 4'b1001);
    check("t3_chord_dir", bus.player_direction, 4'b0000);
    bus.key_n = 4'b1110;
    repeat (6) tick();
    check("t3_dir_early", bus.player_direction, 4'b0000);
    tick();
    check("t3_dir_up", bus.player_direction, 4'b0001);
    bus.key_n = 4'hF;
    repeat (10) tick();

    // 4: held DOWN, auto-repeat pattern (or constant level)
    bus.key_n = 4'b1101;
    wait_dir(4'b0010, "t4_assert");
    for (int k = 1; k < 60; k++) begin
      tick();
`ifdef DIR_REPEAT_EN
      check("t4_pattern", bus.player_direction, ((k % (RepeatCycles + GapCycles)) < RepeatCycles)
                                                ? 4'b0010 : 4'b0000);
`else
      check("t4_pattern", bus.player_direction, 4'b0010);
`endif
    end
    bus.key_n = 4'hF;
    repeat (10) tick();
    check("t4_release", bus.player_direction, 4'b0000);

    // 5: asynchronous reset during a held RIGHT
    bus.key_n = 4'b1011;
    wait_dir(4'b0100, "t5_assert");
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_dir", bus.player_direction, 4'b0000);
    check("t5_async_stable", bus.key_stable, 4'b0000);
    model_reset();
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    check("t5_dir_early", bus.player_direction, 4'b0000);
    tick();
    check("t5_dir_reassert", bus.player_direction, 4'b0100);
    bus.key_n = 4'hF;
    repeat (10) tick();

    // 6: UP to DOWN in one stable update switches with no zero cycle
    bus.key_n = 4'b1110;
    wait_dir(4'b0001, "t6_up");
    bus.key_n = 4'b1101;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("t6_hold_up", bus.player_direction, 4'b0001);
    end
    tick();
    check("t6_down", bus.player_direction, 4'b0010);
    bus.key_n = 4'hF;
    repeat (10) tick();

    // Random key activity against the model
    for (int s = 0; s < 60; s++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      pat = ~(4'b0001 << $urandom_range(0, 3));
      else if (sel == 6) pat = 4'hF;
      else if (sel == 7) pat = 4'($urandom);
      else               pat = ~((4'b0001 << $urandom_range(0, 3)) | (4'b0001 << $urandom_range(0, 3)));
      len = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 60));
      bus.key_n = pat;
      repeat (len) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
